// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache line fill and write-through store initiator
//
// Fetches one full cache line from a pipelined memory on a miss and streams
// the returned words into the cache data array; forwards write-through
// stores to memory while no fill is active.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   miss_detected         miss request (level, held until write_tag_array)
//   miss_address          byte address of the missing access
//   store_req             store request (level, held until store_ack)
//   store_addr/store_data store byte address and data
//   memory_data           memory read data
//   memory_data_valid     memory read data valid
//   mem_enable/mem_wr     memory enable and write strobe
//   mem_addr/mem_data_in  memory byte address and write data
//   fsm_busy              high on every FILL cycle
//   write_data_array      data-array write strobe
//   fill_offset/fill_data data-array word offset and data
//   write_tag_array       pulse when the line is complete
//   store_ack             pulse when the store is issued
module cache_fill_fsm #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WORDS = 8,
   localparam int OFS_W = $clog2(LINE_WORDS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  miss_detected,
   input  logic [ADDR_WIDTH-1:0] miss_address,
   input  logic                  store_req,
   input  logic [ADDR_WIDTH-1:0] store_addr,
   input  logic [15:0]           store_data,
   input  logic [15:0]           memory_data,
   input  logic                  memory_data_valid,
   output logic                  mem_enable,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [15:0]           mem_data_in,
   output logic                  fsm_busy,
   output logic                  write_data_array,
   output logic [OFS_W-1:0]      fill_offset,
   output logic [15:0]           fill_data,
   output logic                  write_tag_array,
   output logic                  store_ack
);

   typedef enum logic {IDLE, FILL} state_t;

   localparam logic [OFS_W:0]      LINE_CNT  = (OFS_W+1)'(LINE_WORDS);
   localparam logic [OFS_W-1:0]    LAST_OFS  = OFS_W'(LINE_WORDS - 1);
   // A line spans 2*LINE_WORDS bytes; clear the word offset and byte bit.
   localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~(ADDR_WIDTH'(2*LINE_WORDS - 1));

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   base;
   logic [OFS_W:0]          issue_cnt;
   logic [OFS_W-1:0]        recv_cnt;

   logic                    issuing;
   logic                    rd_valid;
   logic                    last_word;
   logic                    store_go;
   logic [ADDR_WIDTH-1:0]   issue_addr;

   always_comb begin
      issuing    = (state == FILL) && (issue_cnt < LINE_CNT);
      rd_valid   = (state == FILL) && memory_data_valid;
      last_word  = rd_valid && (recv_cnt == LAST_OFS);
      // A miss wins over a simultaneous store.
      store_go   = (state == IDLE) && !miss_detected && store_req;
      issue_addr = base | ADDR_WIDTH'({issue_cnt[OFS_W-1:0], 1'b0});
   end

   // Outputs are combinational so stores and array writes land in the cycle
   // they are seen; they are gated by rst_n so nothing leaks out during reset.
   always_comb begin
      mem_enable       = rst_n && (issuing || store_go);
      mem_wr           = rst_n && store_go;
      mem_addr         = '0;
      if (rst_n && store_go)
         mem_addr = store_addr;
      else if (rst_n && issuing)
         mem_addr = issue_addr;
      mem_data_in      = rst_n ? store_data : 16'h0000;
      fsm_busy         = rst_n && (state == FILL);
      write_data_array = rst_n && rd_valid;
      fill_offset      = (rst_n && rd_valid) ? recv_cnt : '0;
      fill_data        = memory_data;
      write_tag_array  = rst_n && last_word;
      store_ack        = rst_n && store_go;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         base      <= '0;
         issue_cnt <= '0;
         recv_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_detected) begin
                  base      <= miss_address & BASE_MASK;
                  issue_cnt <= '0;
                  recv_cnt  <= '0;
                  state     <= FILL;
               end
            end
            FILL: begin
               if (issuing)
                  issue_cnt <= issue_cnt + 1'b1;
               // recv_cnt wraps to 0 naturally after the last word.
               if (rd_valid)
                  recv_cnt <= recv_cnt + 1'b1;
               if (last_word)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm
module tb_cache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = 16'h0;
   logic        store_req = 1'b0;
   logic [15:0] store_addr = 16'h0;
   logic [15:0] store_data = 16'h0;
   logic [15:0] memory_data;
   logic        memory_data_valid;
   logic        mem_enable;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_in;
   logic        fsm_busy;
   logic        write_data_array;
   logic [2:0]  fill_offset;
   logic [15:0] fill_data;
   logic        write_tag_array;
   logic        store_ack;

   int n_pass = 0;
   int n_total = 0;

   logic [15:0] q_addr[$];
   logic [2:0]  q_off[$];
   logic [15:0] q_dat[$];

   logic        rand_mode = 1'b0;
   logic        spur = 1'b0;
   logic        rnd_v = 1'b0;
   logic [15:0] rnd_d = 16'h0;

   logic [15:0] mem [0:32767];
   logic [3:0]  pv;
   logic [15:0] pd [4];

   cache_fill_fsm #(.ADDR_WIDTH(16), .LINE_WORDS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .miss_detected(miss_detected), .miss_address(miss_address),
      .store_req(store_req), .store_addr(store_addr), .store_data(store_data),
      .memory_data(memory_data), .memory_data_valid(memory_data_valid),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .fsm_busy(fsm_busy),
      .write_data_array(write_data_array), .fill_offset(fill_offset),
      .fill_data(fill_data), .write_tag_array(write_tag_array),
      .store_ack(store_ack)
   );

   always #5 clk = ~clk;

   assign memory_data       = rand_mode ? rnd_d : pd[3];
   assign memory_data_valid = rand_mode ? rnd_v : (pv[3] | spur);

   // Memory: single-cycle write, 4-cycle pipelined read, shares reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv <= 4'b0;
         for (int i = 0; i < 4; i++) pd[i] <= 16'h0;
      end else begin
         pv    <= {pv[2:0], mem_enable & ~mem_wr};
         pd[0] <= mem[mem_addr[15:1]];
         pd[1] <= pd[0];
         pd[2] <= pd[1];
         pd[3] <= pd[2];
         if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_data_in;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard: pop expected reads and array writes as the DUT produces them.
   always @(negedge clk) begin
      if (rst_n && !rand_mode) begin
         if (mem_enable && !mem_wr) begin
            if (q_addr.size() == 0) chk("unexpected_read", {16'h0, mem_addr}, 32'hFFFFFFFF);
            else chk("read_addr", {16'h0, mem_addr}, {16'h0, q_addr.pop_front()});
         end
         if (write_data_array) begin
            if (q_off.size() == 0) chk("unexpected_write", {29'h0, fill_offset}, 32'hFFFFFFFF);
            else begin
               chk("fill_offset", {29'h0, fill_offset}, {29'h0, q_off.pop_front()});
               chk("fill_data", {16'h0, fill_data}, {16'h0, q_dat.pop_front()});
            end
         end
      end
   end

   // Runs one line fill; returns at the sampling point of the cycle after F11.
   task automatic do_fill(input logic [15:0] a, input logic [15:0] dbase,
                          input logic w_store, input logic ovr0, input logic [15:0] ov);
      int busy_n = 0;
      int tag_at = -1;
      int ack_n = 0;
      for (int n = 0; n < 8; n++) begin
         q_addr.push_back({a[15:4], 4'h0} | 16'(n << 1));
         q_off.push_back(3'(n));
         q_dat.push_back((n == 0 && ovr0) ? ov : dbase + 16'(n));
      end
      @(posedge clk); #1;
      miss_detected = 1'b1;
      miss_address  = a;
      if (w_store) store_req = 1'b1;
      @(negedge clk);
      chk("entry_busy", {31'h0, fsm_busy}, 32'h0);
      chk("entry_mem_en", {31'h0, mem_enable}, 32'h0);
      chk("entry_ack", {31'h0, store_ack}, 32'h0);
      for (int c = 0; c < 30 && tag_at < 0; c++) begin
         @(negedge clk);
         if (fsm_busy) busy_n++;
         if (store_ack) ack_n++;
         if (write_tag_array) tag_at = c;
      end
      @(posedge clk); #1;
      miss_detected = 1'b0;
      @(negedge clk);
      chk("tag_cycle", tag_at, 11);
      chk("busy_cycles", busy_n, 12);
      chk("ack_during_fill", ack_n, 0);
      chk("busy_after", {31'h0, fsm_busy}, 32'h0);
      chk("reads_left", q_addr.size(), 0);
      chk("writes_left", q_off.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int n = 0; n < 8; n++) begin
         mem[16'h1230/2 + n] = 16'hA000 + 16'(n);
         mem[16'h2000/2 + n] = 16'hB000 + 16'(n);
         mem[16'h4000/2 + n] = 16'hC000 + 16'(n);
         mem[16'h0040/2 + n] = 16'hD000 + 16'(n);
      end

      // Reset with random inputs: everything 0 except fill_data.
      rand_mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         miss_detected = 1'($urandom);
         miss_address  = 16'($urandom);
         store_req     = 1'($urandom);
         store_addr    = 16'($urandom);
         store_data    = 16'($urandom);
         rnd_v         = 1'($urandom);
         rnd_d         = 16'($urandom);
         @(negedge clk);
         chk("reset_outputs",
             {mem_enable, mem_wr, mem_addr, mem_data_in, fsm_busy, write_data_array,
              fill_offset, write_tag_array, store_ack}, 32'h0);
         chk("reset_fill_data", {16'h0, fill_data}, {16'h0, rnd_d});
      end
      miss_detected = 1'b0;
      store_req = 1'b0;
      rand_mode = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_busy", {31'h0, fsm_busy}, 32'h0);
         chk("idle_mem_en", {31'h0, mem_enable}, 32'h0);
      end

      // Main fill of 0x1236.
      do_fill(16'h1236, 16'hA000, 1'b0, 1'b0, 16'h0);

      // Write-through store, then read it back through a fill.
      @(posedge clk); #1;
      store_req  = 1'b1;
      store_addr = 16'h0041;
      store_data = 16'hBEEF;
      @(negedge clk);
      chk("st_mem_en", {31'h0, mem_enable}, 32'h1);
      chk("st_mem_wr", {31'h0, mem_wr}, 32'h1);
      chk("st_mem_addr", {16'h0, mem_addr}, 32'h0041);
      chk("st_mem_data", {16'h0, mem_data_in}, 32'hBEEF);
      chk("st_ack", {31'h0, store_ack}, 32'h1);
      @(posedge clk); #1;
      store_req = 1'b0;
      @(negedge clk);
      chk("st_ack_dropped", {31'h0, store_ack}, 32'h0);
      do_fill(16'h0040, 16'hD000, 1'b0, 1'b1, 16'hBEEF);

      // Miss and store rise together: fill first, store right after F11.
      store_addr = 16'h0060;
      store_data = 16'h1111;
      do_fill(16'h1230, 16'hA000, 1'b1, 1'b0, 16'h0);
      chk("conflict_ack", {31'h0, store_ack}, 32'h1);
      chk("conflict_addr", {16'h0, mem_addr}, 32'h0060);
      @(posedge clk); #1;
      store_req = 1'b0;

      // Reset during F6 abandons the line.
      for (int n = 0; n < 8; n++) begin
         q_addr.push_back(16'h2000 | 16'(n << 1));
         q_off.push_back(3'(n));
         q_dat.push_back(16'hB000 + 16'(n));
      end
      @(posedge clk); #1;
      miss_detected = 1'b1;
      miss_address  = 16'h2000;
      @(negedge clk);
      repeat (7) @(negedge clk);
      #2;
      rst_n = 1'b0;
      miss_detected = 1'b0;
      #1;
      chk("midrst_outputs",
          {mem_enable, mem_wr, mem_addr, fsm_busy, write_data_array,
           fill_offset, write_tag_array, store_ack}, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("midrst_tag", {31'h0, write_tag_array}, 32'h0);
      end
      q_addr.delete();
      q_off.delete();
      q_dat.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_fill(16'h4000, 16'hC000, 1'b0, 1'b0, 16'h0);

      // Spurious valid in IDLE is ignored.
      @(posedge clk); #1;
      spur = 1'b1;
      @(negedge clk);
      chk("spur_write", {31'h0, write_data_array}, 32'h0);
      chk("spur_tag", {31'h0, write_tag_array}, 32'h0);
      @(posedge clk); #1;
      spur = 1'b0;
      do_fill(16'h1238, 16'hA000, 1'b0, 1'b0, 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
